// File: rtl/writeback_queue.sv
// In-order writeback FIFO between result producers and the register file.
// Show-ahead head output plus combinational pending lookups for the decode stage.
module writeback_queue #(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 5,
    parameter int DATA_W = 32
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [ADDR_W-1:0]        in_register,
    input  logic [DATA_W-1:0]        in_data,
    input  logic                     flush,
    output logic                     reg_write,
    output logic [ADDR_W-1:0]        write_register,
    output logic [DATA_W-1:0]        write_data,
    input  logic                     wr_ready,
    input  logic [ADDR_W-1:0]        check_register1,
    input  logic [ADDR_W-1:0]        check_register2,
    output logic                     pending1,
    output logic                     pending2,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [ADDR_W-1:0] reg_mem  [DEPTH];
    logic [DATA_W-1:0] data_mem [DEPTH];
    logic [PTR_W-1:0]  rd_ptr, wr_ptr;
    logic              store, dequeue;
    logic [DEPTH-1:0]  hit1, hit2;

    // Writes to r0 complete the handshake but are never queued.
    assign in_ready       = count < CNT_W'(DEPTH);
    assign store          = in_valid && in_ready && (in_register != '0) && !flush;
    assign reg_write      = count != '0;
    assign dequeue        = reg_write && wr_ready;
    assign write_register = reg_write ? reg_mem[rd_ptr]  : '0;
    assign write_data     = reg_write ? data_mem[rd_ptr] : '0;

    // An entry is live when its distance from the head is below count.
    for (genvar i = 0; i < DEPTH; i++) begin : g_entry
        logic [PTR_W-1:0] offset;
        logic             live;
        assign offset  = PTR_W'(i) - rd_ptr;
        assign live    = {1'b0, offset} < count;
        assign hit1[i] = live && (reg_mem[i] == check_register1);
        assign hit2[i] = live && (reg_mem[i] == check_register2);
    end

    assign pending1 = (check_register1 != '0) && (|hit1);
    assign pending2 = (check_register2 != '0) && (|hit2);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (store)   wr_ptr <= wr_ptr + PTR_W'(1);
            if (dequeue) rd_ptr <= rd_ptr + PTR_W'(1);
            if (store && !dequeue)      count <= count + CNT_W'(1);
            else if (!store && dequeue) count <= count - CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (store) begin
            reg_mem[wr_ptr]  <= in_register;
            data_mem[wr_ptr] <= in_data;
        end
    end
endmodule

// File: tb/tb_writeback_queue.sv
// Directed checks of the writeback queue: latency, full/backpressure, r0 drop,
// streaming wrap, flush override and asynchronous reset.
module tb_writeback_queue;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [4:0]  in_register;
    logic [31:0] in_data;
    logic        flush;
    logic        reg_write;
    logic [4:0]  write_register;
    logic [31:0] write_data;
    logic        wr_ready;
    logic [4:0]  check_register1, check_register2;
    logic        pending1, pending2;
    logic [2:0]  count;

    int n_cmp = 0;
    int n_bad = 0;

    writeback_queue #(.DEPTH(4), .ADDR_W(5), .DATA_W(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_register(in_register), .in_data(in_data),
        .flush(flush),
        .reg_write(reg_write), .write_register(write_register), .write_data(write_data),
        .wr_ready(wr_ready),
        .check_register1(check_register1), .check_register2(check_register2),
        .pending1(pending1), .pending2(pending2),
        .count(count)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // Advance one clock; return 1 time unit after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b0; in_register = '0; in_data = '0;
        flush = 1'b0; wr_ready = 1'b0; check_register1 = 5'd0; check_register2 = 5'd0;
        step();
        n_cmp++; if (count !== 3'd0) begin n_bad++; $display("FAIL reset_count got %0d want 0", count); end
        n_cmp++; if (reg_write !== 1'b0) begin n_bad++; $display("FAIL reset_reg_write got %b want 0", reg_write); end
        n_cmp++; if (write_register !== 5'd0 || write_data !== 32'd0) begin n_bad++;
            $display("FAIL reset_head got %0d/%h want 0/0", write_register, write_data); end
        n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
        n_cmp++; if (pending1 !== 1'b0 || pending2 !== 1'b0) begin n_bad++;
            $display("FAIL reset_pending got %b%b want 00", pending1, pending2); end
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_single();
        wr_ready = 1'b0; check_register1 = 5'd5; check_register2 = 5'd6;
        in_valid = 1'b1; in_register = 5'd5; in_data = 32'h1111_1111;
        #1;
        n_cmp++; if (reg_write !== 1'b0) begin n_bad++; $display("FAIL single_no_bypass got %b want 0", reg_write); end
        step();
        in_valid = 1'b0; #1;
        n_cmp++; if (reg_write !== 1'b1 || write_register !== 5'd5 || write_data !== 32'h1111_1111) begin n_bad++;
            $display("FAIL single_head got %b/%0d/%h want 1/5/11111111", reg_write, write_register, write_data); end
        n_cmp++; if (count !== 3'd1) begin n_bad++; $display("FAIL single_count got %0d want 1", count); end
        n_cmp++; if (pending1 !== 1'b1 || pending2 !== 1'b0) begin n_bad++;
            $display("FAIL single_pending got %b%b want 10", pending1, pending2); end
        wr_ready = 1'b1;
        step();
        n_cmp++; if (count !== 3'd0 || reg_write !== 1'b0 || pending1 !== 1'b0) begin n_bad++;
            $display("FAIL single_drain got cnt %0d rw %b p1 %b want 0 0 0", count, reg_write, pending1); end
        wr_ready = 1'b0;
    endtask

    task automatic test_full();
        wr_ready = 1'b0; check_register1 = 5'd3; check_register2 = 5'd9;
        for (int k = 1; k <= 4; k++) begin
            in_valid = 1'b1; in_register = 5'(k); in_data = 32'hA0 + 32'(k);
            step();
            n_cmp++; if (count !== 3'(k)) begin n_bad++; $display("FAIL full_fill%0d count got %0d want %0d", k, count, k); end
        end
        n_cmp++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL full_in_ready got %b want 0", in_ready); end
        n_cmp++; if (pending1 !== 1'b1 || pending2 !== 1'b0) begin n_bad++;
            $display("FAIL full_pending got %b%b want 10", pending1, pending2); end
        // Fifth offer, first with the register file stalled, then with a dequeue.
        in_register = 5'd9; in_data = 32'h99;
        step();
        n_cmp++; if (count !== 3'd4) begin n_bad++; $display("FAIL full_reject count got %0d want 4", count); end
        wr_ready = 1'b1; check_register2 = 5'd1; #1;
        n_cmp++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL full_ready_with_deq got %b want 0", in_ready); end
        n_cmp++; if (pending2 !== 1'b1 || write_register !== 5'd1 || write_data !== 32'hA1) begin n_bad++;
            $display("FAIL full_head1 got p2 %b %0d/%h want 1 1/a1", pending2, write_register, write_data); end
        step();
        in_valid = 1'b0;
        for (int k = 2; k <= 4; k++) begin
            #1;
            n_cmp++; if (reg_write !== 1'b1 || write_register !== 5'(k) || write_data !== 32'hA0 + 32'(k)) begin n_bad++;
                $display("FAIL full_drain%0d got %b/%0d/%h want 1/%0d/%h", k, reg_write, write_register, write_data, k, 32'hA0 + 32'(k)); end
            step();
        end
        n_cmp++; if (reg_write !== 1'b0 || count !== 3'd0) begin n_bad++;
            $display("FAIL full_empty got rw %b cnt %0d want 0 0", reg_write, count); end
        wr_ready = 1'b0;
    endtask

    task automatic test_zero_reg();
        check_register1 = 5'd0; check_register2 = 5'd0;
        in_valid = 1'b1; in_register = 5'd0; in_data = 32'hDEAD_BEEF; #1;
        n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL zero_in_ready got %b want 1", in_ready); end
        step();
        in_valid = 1'b0; #1;
        n_cmp++; if (count !== 3'd0 || reg_write !== 1'b0) begin n_bad++;
            $display("FAIL zero_not_stored got cnt %0d rw %b want 0 0", count, reg_write); end
        n_cmp++; if (pending1 !== 1'b0 || pending2 !== 1'b0) begin n_bad++;
            $display("FAIL zero_pending got %b%b want 00", pending1, pending2); end
    endtask

    task automatic test_back_to_back();
        wr_ready = 1'b1; check_register1 = 5'd0; check_register2 = 5'd0;
        for (int i = 0; i < 10; i++) begin
            in_valid = 1'b1; in_register = 5'(i + 1); in_data = 32'h100 + 32'(i); #1;
            if (i > 0) begin
                n_cmp++; if (count !== 3'd1 || write_register !== 5'(i) || write_data !== 32'h100 + 32'(i - 1)) begin n_bad++;
                    $display("FAIL stream%0d got cnt %0d %0d/%h want 1 %0d/%h", i, count, write_register, write_data, i, 32'h100 + 32'(i - 1)); end
            end
            step();
        end
        in_valid = 1'b0; #1;
        n_cmp++; if (count !== 3'd1 || write_register !== 5'd10 || write_data !== 32'h109) begin n_bad++;
            $display("FAIL stream_last got cnt %0d %0d/%h want 1 10/109", count, write_register, write_data); end
        step();
        n_cmp++; if (count !== 3'd0) begin n_bad++; $display("FAIL stream_empty got %0d want 0", count); end
        wr_ready = 1'b0;
    endtask

    task automatic test_flush();
        wr_ready = 1'b0; check_register1 = 5'd10; check_register2 = 5'd8;
        for (int k = 0; k < 3; k++) begin
            in_valid = 1'b1; in_register = 5'(7 + k); in_data = 32'(k);
            step();
        end
        n_cmp++; if (count !== 3'd3 || pending2 !== 1'b1) begin n_bad++;
            $display("FAIL flush_fill got cnt %0d p2 %b want 3 1", count, pending2); end
        flush = 1'b1; in_register = 5'd10; in_data = 32'h55;
        step();
        flush = 1'b0; in_valid = 1'b0; #1;
        n_cmp++; if (count !== 3'd0 || reg_write !== 1'b0 || in_ready !== 1'b1) begin n_bad++;
            $display("FAIL flush_clear got cnt %0d rw %b rdy %b want 0 0 1", count, reg_write, in_ready); end
        n_cmp++; if (pending1 !== 1'b0 || pending2 !== 1'b0) begin n_bad++;
            $display("FAIL flush_pending got %b%b want 00", pending1, pending2); end
        in_valid = 1'b1; in_register = 5'd12; in_data = 32'hC0DE;
        step();
        in_valid = 1'b0; #1;
        n_cmp++; if (reg_write !== 1'b1 || write_register !== 5'd12 || write_data !== 32'hC0DE || count !== 3'd1) begin n_bad++;
            $display("FAIL flush_reuse got %b/%0d/%h cnt %0d want 1/12/c0de 1", reg_write, write_register, write_data, count); end
        wr_ready = 1'b1;
        step();
        wr_ready = 1'b0;
    endtask

    task automatic test_async_reset();
        wr_ready = 1'b0;
        for (int k = 0; k < 2; k++) begin
            in_valid = 1'b1; in_register = 5'(20 + k); in_data = 32'(k);
            step();
        end
        in_valid = 1'b0;
        n_cmp++; if (count !== 3'd2) begin n_bad++; $display("FAIL areset_fill got %0d want 2", count); end
        #2 rst_n = 1'b0;
        #1;
        n_cmp++; if (count !== 3'd0 || reg_write !== 1'b0) begin n_bad++;
            $display("FAIL areset_immediate got cnt %0d rw %b want 0 0", count, reg_write); end
        #1 rst_n = 1'b1;
        step();
        in_valid = 1'b1; in_register = 5'd11; in_data = 32'hBEEF;
        step();
        in_valid = 1'b0; #1;
        n_cmp++; if (reg_write !== 1'b1 || write_register !== 5'd11 || write_data !== 32'hBEEF || count !== 3'd1) begin n_bad++;
            $display("FAIL areset_after got %b/%0d/%h cnt %0d want 1/11/beef 1", reg_write, write_register, write_data, count); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_full();
        test_zero_reg();
        test_back_to_back();
        test_flush();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
